// File: rtl/flex_pipe_buffer.sv
// flex_pipe_buffer: register-staged bridge between a bus master and its slaves, with a
// dtack watchdog that answers a silent slave with a forced acknowledge and error data.
`ifndef BB_ADDR_BUS_WIDTH
`define BB_ADDR_BUS_WIDTH 16
`endif
`ifndef BB_DATA_BUS_WIDTH
`define BB_DATA_BUS_WIDTH 16
`endif

module flex_pipe_buffer #(
    parameter int unsigned addr_bus_width = `BB_ADDR_BUS_WIDTH,
    parameter int unsigned data_bus_width = `BB_DATA_BUS_WIDTH,
    parameter int unsigned down_stages    = 1,
    parameter int unsigned up_stages      = 1,
    parameter int unsigned timeout_cycles = 64,
    parameter int unsigned timeout_data   = 16'hDEAD
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [addr_bus_width-1:0] addr,
    input  logic [data_bus_width-1:0] data_w,
    output logic [data_bus_width-1:0] data_r,
    input  logic                      addr_strobe,
    input  logic                      read_trg,
    input  logic                      write_trg,
    input  logic                      read_fin,
    input  logic                      write_fin,
    input  logic                      event_trg,
    output logic                      dtack,
    output logic                      data_r_act,
    output logic [addr_bus_width-1:0] sec_addr,
    output logic [data_bus_width-1:0] sec_data_w,
    input  logic [data_bus_width-1:0] sec_data_r,
    output logic                      sec_addr_strobe,
    output logic                      sec_read_trg,
    output logic                      sec_write_trg,
    output logic                      sec_read_fin,
    output logic                      sec_write_fin,
    output logic                      sec_event_trg,
    input  logic                      sec_dtack,
    input  logic                      sec_data_r_act,
    output logic                      timeout_pulse,
    output logic [7:0]                timeout_count,
    output logic                      busy
);

    localparam int unsigned DnWidth = addr_bus_width + data_bus_width + 6;
    localparam int unsigned UpWidth = data_bus_width + 2;
    localparam int DnDepth = int'(down_stages);
    localparam int UpDepth = int'(up_stages);
    localparam bit WdEnable = (timeout_cycles != 0);
    localparam logic [15:0] WdLast = 16'(timeout_cycles - 1);
    localparam logic [data_bus_width-1:0] ToData = data_bus_width'(timeout_data);

    typedef enum logic [1:0] {StIdle, StPend, StAcked, StTout} state_e;

    logic [DnWidth-1:0]        w_dn_in;
    logic [DnWidth-1:0]        w_dn_out;
    logic [UpWidth-1:0]        w_up_in;
    logic [UpWidth-1:0]        w_up_out;
    logic                      w_dtack_p;
    logic                      w_act_p;
    logic [data_bus_width-1:0] w_data_p;
    logic                      w_trg;
    logic                      w_fin;
    logic                      w_wd_hit;
    logic                      w_expire;
    state_e                    w_state_next;
    state_e                    r_state;
    logic [15:0]               r_wd_cnt;
    logic                      r_is_read;
    logic                      r_timeout_pulse;
    logic [7:0]                r_timeout_count;

    assign w_dn_in = {event_trg, write_fin, read_fin, write_trg, read_trg, addr_strobe,
                      data_w, addr};

    generate
        if (DnDepth == 0) begin : g_dn_wire
            assign w_dn_out = w_dn_in;
        end else begin : g_dn_reg
            logic [DnWidth-1:0] r_dn [DnDepth];
            always_ff @(posedge clock) begin
                if (reset) begin
                    for (int i = 0; i < DnDepth; i++) r_dn[i] <= '0;
                end else begin
                    r_dn[0] <= w_dn_in;
                    for (int i = 1; i < DnDepth; i++) r_dn[i] <= r_dn[i-1];
                end
            end
            assign w_dn_out = r_dn[DnDepth-1];
        end
    endgenerate

    assign {sec_event_trg, sec_write_fin, sec_read_fin, sec_write_trg, sec_read_trg,
            sec_addr_strobe, sec_data_w, sec_addr} = w_dn_out;

    assign w_up_in = {sec_dtack, sec_data_r_act, sec_data_r};

    generate
        if (UpDepth == 0) begin : g_up_wire
            assign w_up_out = w_up_in;
        end else begin : g_up_reg
            logic [UpWidth-1:0] r_up [UpDepth];
            always_ff @(posedge clock) begin
                if (reset) begin
                    for (int i = 0; i < UpDepth; i++) r_up[i] <= '0;
                end else begin
                    r_up[0] <= w_up_in;
                    for (int i = 1; i < UpDepth; i++) r_up[i] <= r_up[i-1];
                end
            end
            assign w_up_out = r_up[UpDepth-1];
        end
    endgenerate

    assign {w_dtack_p, w_act_p, w_data_p} = w_up_out;

    // Tracker watches the master side directly, but acks only via the upstream pipeline.
    assign w_trg    = read_trg | write_trg;
    assign w_fin    = read_fin | write_fin;
    assign w_wd_hit = WdEnable && (r_wd_cnt == WdLast);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_expire     = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_trg) w_state_next = StPend;
            end
            StPend: begin
                if (w_dtack_p) begin
                    w_state_next = StAcked;
                end else if (w_wd_hit) begin
                    w_state_next = StTout;
                    w_expire     = 1'b1;
                end else if (w_fin) begin
                    w_state_next = StIdle;
                end
            end
            StAcked, StTout: begin
                if (w_fin) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wd_cnt        <= '0;
            r_is_read       <= 1'b0;
            r_timeout_pulse <= 1'b0;
            r_timeout_count <= '0;
        end else begin
            r_timeout_pulse <= w_expire;
            if (r_state == StIdle && w_trg) begin
                r_wd_cnt  <= '0;
                r_is_read <= read_trg;
            end else if (r_state == StPend) begin
                r_wd_cnt <= r_wd_cnt + 16'd1;
            end
            if (w_expire && r_timeout_count != 8'hFF) begin
                r_timeout_count <= r_timeout_count + 8'd1;
            end
        end
    end

    // A forced response hides whatever is still travelling up the pipeline.
    always_comb begin
        dtack      = w_dtack_p;
        data_r     = w_data_p;
        data_r_act = w_act_p;
        if (r_state == StTout) begin
            dtack      = 1'b1;
            data_r     = r_is_read ? ToData : '0;
            data_r_act = r_is_read;
        end
    end

    assign timeout_pulse = r_timeout_pulse;
    assign timeout_count = r_timeout_count;
    assign busy          = (r_state != StIdle);

endmodule

// File: tb/tb_flex_pipe_buffer.sv
// Bench for flex_pipe_buffer: three configurations share one stimulus stream and are
// compared every cycle against a timestamp-based reference model.
module tb_flex_pipe_buffer;

    localparam int MAXC = 8192;
    localparam logic [2:0][7:0]  DSP = {8'd3, 8'd0, 8'd2};
    localparam logic [2:0][7:0]  USP = {8'd2, 8'd0, 8'd1};
    localparam logic [2:0][15:0] TOP = {16'd0, 16'd4, 16'd8};

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic [15:0] addr, data_w, sec_data_r;
    logic        addr_strobe, read_trg, write_trg, read_fin, write_fin, event_trg;
    logic        sec_dtack, sec_data_r_act;

    logic [15:0] o_data_r [3];
    logic [15:0] o_sec_addr [3];
    logic [15:0] o_sec_data_w [3];
    logic        o_dtack [3];
    logic        o_act [3];
    logic        o_sas [3];
    logic        o_srt [3];
    logic        o_swt [3];
    logic        o_srf [3];
    logic        o_swf [3];
    logic        o_sev [3];
    logic        o_tp [3];
    logic        o_busy [3];
    logic [7:0]  o_tc [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        flex_pipe_buffer #(
            .addr_bus_width(16),
            .data_bus_width(16),
            .down_stages   (32'(DSP[g])),
            .up_stages     (32'(USP[g])),
            .timeout_cycles(32'(TOP[g])),
            .timeout_data  (16'hDEAD)
        ) u_dut (
            .clock          (clock),
            .reset          (reset),
            .addr           (addr),
            .data_w         (data_w),
            .data_r         (o_data_r[g]),
            .addr_strobe    (addr_strobe),
            .read_trg       (read_trg),
            .write_trg      (write_trg),
            .read_fin       (read_fin),
            .write_fin      (write_fin),
            .event_trg      (event_trg),
            .dtack          (o_dtack[g]),
            .data_r_act     (o_act[g]),
            .sec_addr       (o_sec_addr[g]),
            .sec_data_w     (o_sec_data_w[g]),
            .sec_data_r     (sec_data_r),
            .sec_addr_strobe(o_sas[g]),
            .sec_read_trg   (o_srt[g]),
            .sec_write_trg  (o_swt[g]),
            .sec_read_fin   (o_srf[g]),
            .sec_write_fin  (o_swf[g]),
            .sec_event_trg  (o_sev[g]),
            .sec_dtack      (sec_dtack),
            .sec_data_r_act (sec_data_r_act),
            .timeout_pulse  (o_tp[g]),
            .timeout_count  (o_tc[g]),
            .busy           (o_busy[g])
        );
    end

    int cyc = 0;
    int tests = 0;
    int fails = 0;

    // Input history, one entry per cycle; ctl = {strobe, rd_trg, wr_trg, rd_fin, wr_fin, evt}.
    logic [15:0] h_addr [MAXC];
    logic [15:0] h_dw [MAXC];
    logic [15:0] h_sdr [MAXC];
    logic [5:0]  h_ctl [MAXC];
    logic [1:0]  h_up [MAXC];
    logic        h_rst [MAXC];

    // Model: 0 idle, 1 waiting for ack, 2 acked, 3 forced response.
    int mst [3];
    int t0 [3];
    int mcnt [3];
    bit mread [3];
    bit mpulse [3];

    task automatic chk(input string nm, input int inst, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s dut%0d cycle %0d: got %0h, expected %0h", nm, inst, cyc, got,
                     exp);
        end
    endtask

    function automatic logic [31:0] hist(input int sel, input int m);
        case (sel)
            0:       return 32'(h_addr[m]);
            1:       return 32'(h_dw[m]);
            2:       return 32'(h_ctl[m]);
            3:       return 32'(h_sdr[m]);
            default: return 32'(h_up[m]);
        endcase
    endfunction

    // Value seen k clocks later; any reset sampled along the way leaves zero behind.
    function automatic logic [31:0] dly(input int sel, input int m, input int k);
        if (k == 0) return hist(sel, m);
        for (int j = m - k; j < m; j++) begin
            if (j < 0 || h_rst[j]) return 32'd0;
        end
        return hist(sel, m - k);
    endfunction

    task automatic model_cmp(input int i);
        int ds, us;
        logic [31:0] up, dr;
        logic [15:0] e_dr;
        logic e_dt, e_act;
        ds = int'(DSP[i]);
        us = int'(USP[i]);
        up = dly(4, cyc, us);
        dr = dly(3, cyc, us);
        e_dt = up[1];
        e_act = up[0];
        e_dr = dr[15:0];
        if (mst[i] == 3) begin
            e_dt = 1'b1;
            e_act = mread[i];
            e_dr = mread[i] ? 16'hDEAD : 16'h0000;
        end
        chk("sec_addr", i, 32'(o_sec_addr[i]), dly(0, cyc, ds));
        chk("sec_data_w", i, 32'(o_sec_data_w[i]), dly(1, cyc, ds));
        chk("sec_ctl", i, 32'({o_sas[i], o_srt[i], o_swt[i], o_srf[i], o_swf[i], o_sev[i]}),
            dly(2, cyc, ds));
        chk("data_r", i, 32'(o_data_r[i]), 32'(e_dr));
        chk("dtack", i, 32'(o_dtack[i]), 32'(e_dt));
        chk("data_r_act", i, 32'(o_act[i]), 32'(e_act));
        chk("busy", i, 32'(o_busy[i]), 32'(mst[i] != 0));
        chk("timeout_pulse", i, 32'(o_tp[i]), 32'(mpulse[i]));
        chk("timeout_count", i, 32'(o_tc[i]), 32'(mcnt[i]));
    endtask

    task automatic model_upd();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] up;
            logic [5:0] c;
            int to;
            c = h_ctl[cyc];
            to = int'(TOP[i]);
            up = dly(4, cyc, int'(USP[i]));
            if (h_rst[cyc]) begin
                mst[i] = 0;
                mcnt[i] = 0;
                mpulse[i] = 1'b0;
            end else begin
                mpulse[i] = 1'b0;
                case (mst[i])
                    0: if (c[4] || c[3]) begin
                        mst[i] = 1;
                        t0[i] = cyc;
                        mread[i] = c[4];
                    end
                    1: if (up[1]) begin
                        mst[i] = 2;
                    end else if (to != 0 && cyc == t0[i] + to) begin
                        mst[i] = 3;
                        mpulse[i] = 1'b1;
                        if (mcnt[i] < 255) mcnt[i]++;
                    end else if (c[2] || c[1]) begin
                        mst[i] = 0;
                    end
                    default: if (c[2] || c[1]) mst[i] = 0;
                endcase
            end
        end
    endtask

    task automatic cyc_begin();
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget: got cycle %0d, limit %0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        h_addr[cyc] = addr;
        h_dw[cyc] = data_w;
        h_sdr[cyc] = sec_data_r;
        h_ctl[cyc] = {addr_strobe, read_trg, write_trg, read_fin, write_fin, event_trg};
        h_up[cyc] = {sec_dtack, sec_data_r_act};
        h_rst[cyc] = reset;
        @(negedge clock);
        if (cyc >= 1) begin
            for (int i = 0; i < 3; i++) model_cmp(i);
        end
    endtask

    task automatic cyc_end();
        model_upd();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic tick();
        cyc_begin();
        cyc_end();
    endtask

    task automatic clr();
        reset = 1'b0;
        addr = '0;
        data_w = '0;
        sec_data_r = '0;
        addr_strobe = 1'b0;
        read_trg = 1'b0;
        write_trg = 1'b0;
        read_fin = 1'b0;
        write_fin = 1'b0;
        event_trg = 1'b0;
        sec_dtack = 1'b0;
        sec_data_r_act = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            mst[i] = 0;
            t0[i] = 0;
            mcnt[i] = 0;
            mread[i] = 1'b0;
            mpulse[i] = 1'b0;
        end
        clr();
        reset = 1'b1;
        addr = 16'hFFFF;
        @(posedge clock);
        #1;
        tick();
        cyc_begin();
        chk("lit_reset_busy", 0, 32'(o_busy[0]), 0);
        chk("lit_reset_count", 0, 32'(o_tc[0]), 0);
        chk("lit_reset_sec_addr", 0, 32'(o_sec_addr[0]), 0);
        chk("lit_reset_wire_addr", 1, 32'(o_sec_addr[1]), 32'h0000FFFF);
        cyc_end();

        // Pipeline latency.
        for (int k = 0; k < 8; k++) begin
            clr();
            if (k == 0) begin
                addr = 16'h1234;
                addr_strobe = 1'b1;
            end
            if (k == 5) begin
                sec_dtack = 1'b1;
                sec_data_r = 16'hBEEF;
            end
            cyc_begin();
            if (k == 0) begin
                chk("lit_wire_addr", 1, 32'(o_sec_addr[1]), 32'h1234);
                chk("lit_wire_strobe", 1, 32'(o_sas[1]), 1);
            end
            if (k == 1) chk("lit_pipe_strobe_early", 0, 32'(o_sas[0]), 0);
            if (k == 2) begin
                chk("lit_pipe_addr", 0, 32'(o_sec_addr[0]), 32'h1234);
                chk("lit_pipe_strobe", 0, 32'(o_sas[0]), 1);
            end
            if (k == 5) begin
                chk("lit_wire_data_r", 1, 32'(o_data_r[1]), 32'hBEEF);
                chk("lit_pipe_dtack_early", 0, 32'(o_dtack[0]), 0);
            end
            if (k == 6) begin
                chk("lit_pipe_dtack", 0, 32'(o_dtack[0]), 1);
                chk("lit_count_zero", 0, 32'(o_tc[0]), 0);
            end
            cyc_end();
        end

        // Read timeout.
        for (int k = 0; k < 14; k++) begin
            clr();
            if (k == 0) read_trg = 1'b1;
            if (k == 12) read_fin = 1'b1;
            cyc_begin();
            if (k == 8) begin
                chk("lit_rd_dtack_before", 0, 32'(o_dtack[0]), 0);
                chk("lit_rd_pulse_before", 0, 32'(o_tp[0]), 0);
            end
            if (k == 9) begin
                chk("lit_rd_dtack", 0, 32'(o_dtack[0]), 1);
                chk("lit_rd_data", 0, 32'(o_data_r[0]), 32'hDEAD);
                chk("lit_rd_act", 0, 32'(o_act[0]), 1);
                chk("lit_rd_pulse", 0, 32'(o_tp[0]), 1);
                chk("lit_rd_count", 0, 32'(o_tc[0]), 1);
            end
            if (k == 10) begin
                chk("lit_rd_pulse_after", 0, 32'(o_tp[0]), 0);
                chk("lit_rd_busy", 0, 32'(o_busy[0]), 1);
            end
            if (k == 4) chk("lit_rd4_dtack_before", 1, 32'(o_dtack[1]), 0);
            if (k == 5) chk("lit_rd4_data", 1, 32'(o_data_r[1]), 32'hDEAD);
            if (k == 13) chk("lit_rd_busy_done", 0, 32'(o_busy[0]), 0);
            cyc_end();
        end

        // Write timeout.
        for (int k = 0; k < 12; k++) begin
            clr();
            if (k == 0) write_trg = 1'b1;
            if (k == 10) write_fin = 1'b1;
            cyc_begin();
            if (k == 4) chk("lit_wr_dtack_before", 1, 32'(o_dtack[1]), 0);
            if (k == 5) begin
                chk("lit_wr_dtack", 1, 32'(o_dtack[1]), 1);
                chk("lit_wr_act", 1, 32'(o_act[1]), 0);
                chk("lit_wr_count", 1, 32'(o_tc[1]), 2);
            end
            if (k == 11) chk("lit_wr_busy_done", 1, 32'(o_busy[1]), 0);
            cyc_end();
        end

        // Ack lands exactly in the expiry cycle.
        for (int k = 0; k < 12; k++) begin
            clr();
            if (k == 0) read_trg = 1'b1;
            if (k == 7) begin
                sec_dtack = 1'b1;
                sec_data_r_act = 1'b1;
                sec_data_r = 16'h1111;
            end
            if (k == 10) read_fin = 1'b1;
            cyc_begin();
            if (k == 8) begin
                chk("lit_edge_dtack", 0, 32'(o_dtack[0]), 1);
                chk("lit_edge_data", 0, 32'(o_data_r[0]), 32'h1111);
            end
            if (k == 9) begin
                chk("lit_edge_pulse", 0, 32'(o_tp[0]), 0);
                chk("lit_edge_count", 0, 32'(o_tc[0]), 2);
                chk("lit_edge_busy", 0, 32'(o_busy[0]), 1);
            end
            if (k == 11) chk("lit_edge_busy_done", 0, 32'(o_busy[0]), 0);
            cyc_end();
        end

        // Reset while waiting for an ack.
        for (int k = 0; k < 8; k++) begin
            clr();
            if (k >= 3) addr = 16'hA5A5;
            if (k == 0 || k == 5) reset = 1'b1;
            if (k == 2) read_trg = 1'b1;
            cyc_begin();
            if (k == 4) chk("lit_rst_busy_pend", 0, 32'(o_busy[0]), 1);
            if (k == 6) begin
                for (int i = 0; i < 3; i++) begin
                    chk("lit_rst_busy", i, 32'(o_busy[i]), 0);
                    chk("lit_rst_count", i, 32'(o_tc[i]), 0);
                end
                chk("lit_rst_sec_addr", 0, 32'(o_sec_addr[0]), 0);
                chk("lit_rst_dtack", 0, 32'(o_dtack[0]), 0);
            end
            cyc_end();
        end

        // Random traffic.
        for (int k = 0; k < 1500; k++) begin
            clr();
            reset = ($urandom_range(0, 399) == 0);
            addr = 16'($urandom);
            data_w = 16'($urandom);
            sec_data_r = 16'($urandom);
            addr_strobe = ($urandom_range(0, 2) == 0);
            read_trg = ($urandom_range(0, 11) == 0);
            write_trg = ($urandom_range(0, 11) == 0);
            read_fin = ($urandom_range(0, 15) == 0);
            write_fin = ($urandom_range(0, 15) == 0);
            event_trg = ($urandom_range(0, 3) == 0);
            sec_dtack = ($urandom_range(0, 9) == 0);
            sec_data_r_act = ($urandom_range(0, 7) == 0);
            tick();
        end

        // Back-to-back timeouts drive the counter into saturation.
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < 13; k++) begin
                clr();
                if (k == 0) begin
                    read_trg = n[0];
                    write_trg = ~n[0];
                end
                if (k == 11) read_fin = 1'b1;
                tick();
            end
        end
        cyc_begin();
        chk("lit_sat_count", 0, 32'(o_tc[0]), 255);
        chk("lit_sat_count", 1, 32'(o_tc[1]), 255);
        chk("lit_nowd_count", 2, 32'(o_tc[2]), 0);
        cyc_end();

        // Disabled watchdog holds a transaction indefinitely.
        for (int k = 0; k < 103; k++) begin
            clr();
            if (k == 0) read_trg = 1'b1;
            if (k == 101) read_fin = 1'b1;
            cyc_begin();
            if (k == 100) begin
                chk("lit_nowd_busy", 2, 32'(o_busy[2]), 1);
                chk("lit_nowd_dtack", 2, 32'(o_dtack[2]), 0);
                chk("lit_nowd_count_hold", 2, 32'(o_tc[2]), 0);
            end
            if (k == 102) chk("lit_nowd_busy_done", 2, 32'(o_busy[2]), 0);
            cyc_end();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
